multi_edge_detector: RTL and testbench
======================================

MULTI_EDGE_DETECTOR -- requirements
Module: multi_edge_detector

Interface
REQ-001 SHALL have parameter N_CH, default 4, meaning number of independent input channels (1..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning synchroniser flops per channel (1..4).
REQ-003 SHALL have parameter FILT_CYCLES, default 1, meaning consecutive stable cycles before a level change is accepted (1 = no filtering; 1..255).
REQ-004 SHALL have parameter CNT_W, default 8, meaning width of each per-channel event counter.
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 sig_in  in  N_CH  asynchronous raw inputs, bit i = channel i.
REQ-008 mode  in  2*N_CH  per-channel mode, bits [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both.
REQ-009 clr  in  N_CH  per-channel clear of sticky flag and counter.
REQ-010 level_out  out  N_CH  filtered, synchronised level.
REQ-011 edge_pulse  out  N_CH  one-cycle pulse on a qualifying edge.
REQ-012 rise_pulse / fall_pulse  out  N_CH each  one-cycle pulse per accepted rising / falling level change, independent of mode.
REQ-013 sticky  out  N_CH  latched "qualifying edge seen" flag.
REQ-014 event_cnt  out  N_CH*CNT_W  saturating qualifying-edge counts, channel i at [i*CNT_W +: CNT_W].

Function
REQ-015 Each channel SHALL pass sig_in through a SYNC_STAGES flop chain; sync = last stage.
REQ-016 Filter: a per-channel counter SHALL increment each cycle sync != level_out and reset to 0 when sync == level_out; level_out SHALL toggle on the edge where the FILT_CYCLES-th consecutive mismatch is seen, counter returning to 0.
REQ-017 A mismatch run interrupted by one matching cycle SHALL restart the count (glitches shorter than FILT_CYCLES cycles are rejected).
REQ-018 rise_pulse/fall_pulse SHALL be registered and asserted for exactly the one cycle following the edge on which level_out changes 0->1 / 1->0.
REQ-019 Latency: an input change first sampled on edge k SHALL produce level_out change and pulses after edge k+SYNC_STAGES+FILT_CYCLES-1.
REQ-020 edge_pulse SHALL equal (rise_pulse & mode[0]) | (fall_pulse & mode[1]) per channel, registered alongside them; mode 00 produces no edge_pulse, sticky set or count, while level tracking continues.
REQ-021 Mode changes SHALL take effect for the next accepted level change; no pulse is generated by a mode change alone.
REQ-022 sticky SHALL set on edge_pulse and hold until clr.
REQ-023 event_cnt SHALL increment by 1 per edge_pulse and saturate at 2^CNT_W-1 (no wrap).
REQ-024 clr and edge_pulse in the same cycle: sticky SHALL end 1 and counter SHALL end 1 (event wins over clear).
REQ-025 Channels SHALL be fully independent; simultaneous events on any channels SHALL all be reported in the same cycle.

Reset
REQ-026 rst SHALL clear sync chains, filter counters, level_out, all pulses, sticky and event_cnt to 0 on the next clock edge.
REQ-027 An input held high through reset SHALL produce one rise event after reset release, with REQ-019 latency counted from the first non-reset edge.
REQ-028 Reset asserted mid-filter or mid-pulse SHALL abort it; no event SHALL be emitted for that pending change.

Structure
REQ-029 Mode encodings (MODE_OFF, MODE_RISE, MODE_FALL, MODE_BOTH) SHALL live in shared package multi_edge_pkg.
REQ-030 Per-channel logic SHALL be sub-module edge_chan, instantiated N_CH times via generate.

Verification
REQ-031 N_CH=4, SYNC_STAGES=2, FILT_CYCLES=1, mode=11 ch0; sig_in[0] 0->1 sampled edge 0 -> rise_pulse[0] and edge_pulse[0] high for one cycle after edge 2, level_out[0]=1, event_cnt ch0=1.
REQ-032 FILT_CYCLES=4; 3-cycle high glitch on ch1 -> no pulse, level_out[1] stays 0; 4-cycle high -> one rise pulse.
REQ-033 mode ch2=10; rise then fall -> rise_pulse once, no edge_pulse on rise; edge_pulse and sticky[2] set on fall only.
REQ-034 CNT_W=2; 5 qualifying edges on ch3 -> event_cnt ch3 sequence 1,2,3,3,3; clr coinciding with 6th edge -> count 1, sticky 1.
REQ-035 Toggle ch0-ch3 on the same cycle -> all four edge_pulse bits high in the same cycle.
REQ-036 sig_in high during rst, rst released -> single rise event at REQ-019 latency; rst asserted mid-filter -> no event, all outputs 0.

Source files
------------

// File: rtl/multi_edge_pkg.sv
// -----------------------------------------------------------------------------
// multi_edge_pkg
// Shared definitions for the multi-channel edge detector.
//   - per-channel mode encodings (2 bits: bit0 = rising, bit1 = falling)
//   - width of the per-channel glitch filter counter
//   - helper that decides whether an accepted level change qualifies as an
//     event for a given mode
// -----------------------------------------------------------------------------
package multi_edge_pkg;

    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_RISE = 2'b01;
    localparam logic [1:0] MODE_FALL = 2'b10;
    localparam logic [1:0] MODE_BOTH = 2'b11;

    // Wide enough for FILT_CYCLES up to 255.
    localparam int FILT_CNT_W = 8;

    // Mode bit 0 enables rising events, bit 1 enables falling events.
    function automatic logic mode_qualifies(input logic [1:0] mode,
                                            input logic       rise,
                                            input logic       fall);
        return (rise & ((mode & MODE_RISE) != MODE_OFF)) |
               (fall & ((mode & MODE_FALL) != MODE_OFF));
    endfunction

endpackage

// File: rtl/edge_chan.sv
// -----------------------------------------------------------------------------
// edge_chan
// One channel of the edge detector: synchroniser chain, consecutive-mismatch
// glitch filter, registered rise/fall/edge pulses, sticky flag and a
// saturating event counter.
//
// Ports
//   clk, rst   : clock, synchronous active-high reset
//   i_sig      : asynchronous raw input
//   i_mode     : 2-bit mode (off / rise / fall / both)
//   i_clr      : clear sticky flag and counter
//   o_level    : filtered, synchronised level
//   o_rise     : one-cycle pulse after an accepted 0->1 change
//   o_fall     : one-cycle pulse after an accepted 1->0 change
//   o_edge     : one-cycle pulse after a change that qualifies under i_mode
//   o_sticky   : set by o_edge, held until i_clr
//   o_cnt      : saturating count of o_edge pulses
// -----------------------------------------------------------------------------
module edge_chan
    import multi_edge_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 1,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_sig,
    input  logic [1:0]       i_mode,
    input  logic             i_clr,
    output logic             o_level,
    output logic             o_rise,
    output logic             o_fall,
    output logic             o_edge,
    output logic             o_sticky,
    output logic [CNT_W-1:0] o_cnt
);

    localparam logic [FILT_CNT_W-1:0] FILT_LAST = FILT_CNT_W'(FILT_CYCLES - 1);
    localparam logic [CNT_W-1:0]      CNT_MAX   = '1;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [FILT_CNT_W-1:0]  r_filt;
    logic                   r_level;
    logic                   r_rise;
    logic                   r_fall;
    logic                   r_edge;
    logic                   r_sticky;
    logic [CNT_W-1:0]       r_cnt;

    logic w_sync;
    logic w_mismatch;
    logic w_accept;
    logic w_rise;
    logic w_fall;

    assign w_sync     = r_sync[SYNC_STAGES-1];
    assign w_mismatch = w_sync ^ r_level;
    // The change is accepted on the FILT_CYCLES-th consecutive mismatch.
    assign w_accept   = w_mismatch && (r_filt == FILT_LAST);
    assign w_rise     = w_accept & w_sync;
    assign w_fall     = w_accept & ~w_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync[0] <= i_sig;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
        end
    end

    // Any matching cycle (or an accepted change) restarts the mismatch run,
    // so glitches shorter than FILT_CYCLES never reach r_level.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_filt  <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_edge  <= 1'b0;
        end else begin
            if (w_mismatch && !w_accept) begin
                r_filt <= r_filt + FILT_CNT_W'(1);
            end else begin
                r_filt <= '0;
            end
            if (w_accept) begin
                r_level <= w_sync;
            end
            r_rise <= w_rise;
            r_fall <= w_fall;
            // Mode is sampled at the accepting edge, so a mode change alone
            // never produces a pulse.
            r_edge <= mode_qualifies(i_mode, w_rise, w_fall);
        end
    end

    // Sticky and counter follow the visible edge pulse; when a clear lands in
    // the same cycle as the pulse, the event is kept and the count restarts
    // at one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sticky <= 1'b0;
            r_cnt    <= '0;
        end else if (r_edge) begin
            r_sticky <= 1'b1;
            if (i_clr) begin
                r_cnt <= CNT_W'(1);
            end else if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end else if (i_clr) begin
            r_sticky <= 1'b0;
            r_cnt    <= '0;
        end
    end

    assign o_level  = r_level;
    assign o_rise   = r_rise;
    assign o_fall   = r_fall;
    assign o_edge   = r_edge;
    assign o_sticky = r_sticky;
    assign o_cnt    = r_cnt;

endmodule

// File: rtl/multi_edge_detector.sv
// -----------------------------------------------------------------------------
// multi_edge_detector
// N_CH independent edge-detector channels sharing one clock and reset.
//
// Ports
//   clk        : clock, all logic on the rising edge
//   rst        : synchronous active-high reset
//   sig_in     : raw asynchronous inputs, bit i = channel i
//   mode       : per-channel mode at [2i+1:2i] (00 off, 01 rise, 10 fall, 11 both)
//   clr        : per-channel clear of sticky flag and counter
//   level_out  : filtered, synchronised levels
//   edge_pulse : one-cycle pulses for qualifying edges
//   rise_pulse : one-cycle pulses for accepted rising changes (mode independent)
//   fall_pulse : one-cycle pulses for accepted falling changes (mode independent)
//   sticky     : latched "qualifying edge seen" flags
//   event_cnt  : saturating counts, channel i at [i*CNT_W +: CNT_W]
// -----------------------------------------------------------------------------
module multi_edge_detector
    import multi_edge_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 1,
    parameter int CNT_W       = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH-1:0]       sig_in,
    input  logic [2*N_CH-1:0]     mode,
    input  logic [N_CH-1:0]       clr,
    output logic [N_CH-1:0]       level_out,
    output logic [N_CH-1:0]       edge_pulse,
    output logic [N_CH-1:0]       rise_pulse,
    output logic [N_CH-1:0]       fall_pulse,
    output logic [N_CH-1:0]       sticky,
    output logic [N_CH*CNT_W-1:0] event_cnt
);

    for (genvar g = 0; g < N_CH; g++) begin : g_chan
        edge_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_CYCLES (FILT_CYCLES),
            .CNT_W       (CNT_W)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .i_sig    (sig_in[g]),
            .i_mode   (mode[2*g +: 2]),
            .i_clr    (clr[g]),
            .o_level  (level_out[g]),
            .o_rise   (rise_pulse[g]),
            .o_fall   (fall_pulse[g]),
            .o_edge   (edge_pulse[g]),
            .o_sticky (sticky[g]),
            .o_cnt    (event_cnt[g*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_multi_edge_detector.sv
// -----------------------------------------------------------------------------
// tb_multi_edge_detector
// Two detector instances share the same stimulus: dut_a (no filtering, 8-bit
// counters) and dut_b (4-cycle filter, 2-bit counters). A reference model
// tracks both: inputs are delayed through a sample queue, and a level change
// is accepted when the last FILT_CYCLES synchronised samples all disagree
// with the current level.
// -----------------------------------------------------------------------------
module tb_multi_edge_detector;

    localparam int N_CH = 4;
    localparam int SYNC = 2;
    localparam int F_A  = 1;
    localparam int F_B  = 4;
    localparam int CW_A = 8;
    localparam int CW_B = 2;

    // ---------------- clock / reset / DUT ----------------
    logic clk = 1'b0;
    logic rst;
    logic [N_CH-1:0]   sig_in;
    logic [2*N_CH-1:0] mode;
    logic [N_CH-1:0]   clr;

    logic [N_CH-1:0]      lvl_a, edge_a, rise_a, fall_a, sticky_a;
    logic [N_CH*CW_A-1:0] cnt_a;
    logic [N_CH-1:0]      lvl_b, edge_b, rise_b, fall_b, sticky_b;
    logic [N_CH*CW_B-1:0] cnt_b;

    always #5 clk = ~clk;

    multi_edge_detector #(
        .N_CH(N_CH), .SYNC_STAGES(SYNC), .FILT_CYCLES(F_A), .CNT_W(CW_A)
    ) dut_a (
        .clk(clk), .rst(rst), .sig_in(sig_in), .mode(mode), .clr(clr),
        .level_out(lvl_a), .edge_pulse(edge_a), .rise_pulse(rise_a),
        .fall_pulse(fall_a), .sticky(sticky_a), .event_cnt(cnt_a)
    );

    multi_edge_detector #(
        .N_CH(N_CH), .SYNC_STAGES(SYNC), .FILT_CYCLES(F_B), .CNT_W(CW_B)
    ) dut_b (
        .clk(clk), .rst(rst), .sig_in(sig_in), .mode(mode), .clr(clr),
        .level_out(lvl_b), .edge_pulse(edge_b), .rise_pulse(rise_b),
        .fall_pulse(fall_b), .sticky(sticky_b), .event_cnt(cnt_b)
    );

    // ---------------- scoreboard state ----------------
    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    int filt[2] = '{F_A, F_B};
    int cmax[2] = '{(1 << CW_A) - 1, (1 << CW_B) - 1};

    // Model index i = d*N_CH + c (d = 0 for dut_a, 1 for dut_b).
    bit pipe[N_CH][$];
    bit win[2*N_CH][$];
    bit m_level[2*N_CH];
    bit m_rise[2*N_CH];
    bit m_fall[2*N_CH];
    bit m_edge[2*N_CH];
    bit m_sticky[2*N_CH];
    int m_cnt[2*N_CH];

    int n_rise[2*N_CH];
    int n_edge[2*N_CH];

    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // ---------------- reference model ----------------
    always @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < N_CH; c++) begin
                pipe[c].delete();
                for (int s = 0; s < SYNC; s++) pipe[c].push_back(1'b0);
            end
            for (int i = 0; i < 2*N_CH; i++) begin
                win[i].delete();
                m_level[i]  = 1'b0;
                m_rise[i]   = 1'b0;
                m_fall[i]   = 1'b0;
                m_edge[i]   = 1'b0;
                m_sticky[i] = 1'b0;
                m_cnt[i]    = 0;
            end
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                bit s;
                bit acc;
                int i;
                s = pipe[c].pop_front();
                pipe[c].push_back(sig_in[c]);
                for (int d = 0; d < 2; d++) begin
                    i = d*N_CH + c;
                    if (m_edge[i]) begin
                        m_sticky[i] = 1'b1;
                        if (clr[c])                m_cnt[i] = 1;
                        else if (m_cnt[i] < cmax[d]) m_cnt[i] = m_cnt[i] + 1;
                    end else if (clr[c]) begin
                        m_sticky[i] = 1'b0;
                        m_cnt[i]    = 0;
                    end
                    win[i].push_back(s);
                    if (win[i].size() > filt[d]) void'(win[i].pop_front());
                    acc = (win[i].size() == filt[d]);
                    for (int j = 0; j < win[i].size(); j++)
                        if (win[i][j] == m_level[i]) acc = 1'b0;
                    m_rise[i] = acc && s;
                    m_fall[i] = acc && !s;
                    if (acc) m_level[i] = s;
                    m_edge[i] = (m_rise[i] && mode[2*c]) || (m_fall[i] && mode[2*c+1]);
                end
            end
        end
    end

    // ---------------- cycle-by-cycle comparison ----------------
    always @(negedge clk) begin
        logic [N_CH-1:0] el[2], er[2], ef[2], ee[2], es[2];
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                for (int c = 0; c < N_CH; c++) begin
                    el[d][c] = m_level[d*N_CH+c];
                    er[d][c] = m_rise[d*N_CH+c];
                    ef[d][c] = m_fall[d*N_CH+c];
                    ee[d][c] = m_edge[d*N_CH+c];
                    es[d][c] = m_sticky[d*N_CH+c];
                end
            end
            check("a.level",  32'(lvl_a),    32'(el[0]));
            check("a.rise",   32'(rise_a),   32'(er[0]));
            check("a.fall",   32'(fall_a),   32'(ef[0]));
            check("a.edge",   32'(edge_a),   32'(ee[0]));
            check("a.sticky", 32'(sticky_a), 32'(es[0]));
            check("b.level",  32'(lvl_b),    32'(el[1]));
            check("b.rise",   32'(rise_b),   32'(er[1]));
            check("b.fall",   32'(fall_b),   32'(ef[1]));
            check("b.edge",   32'(edge_b),   32'(ee[1]));
            check("b.sticky", 32'(sticky_b), 32'(es[1]));
            for (int c = 0; c < N_CH; c++) begin
                check("a.cnt", 32'(cnt_a[c*CW_A +: CW_A]), 32'(m_cnt[c]));
                check("b.cnt", 32'(cnt_b[c*CW_B +: CW_B]), 32'(m_cnt[N_CH+c]));
                if (rise_a[c]) n_rise[c]++;
                if (edge_a[c]) n_edge[c]++;
                if (rise_b[c]) n_rise[N_CH+c]++;
                if (edge_b[c]) n_edge[N_CH+c]++;
            end
        end
    end

    // ---------------- directed + random stimulus ----------------
    initial begin
        int base_r;
        int base_e;
        int k;
        int hold[N_CH];

        rst    = 1'b1;
        sig_in = '0;
        clr    = '0;
        mode   = '1;
        tick(2);
        chk_en = 1'b1;
        check("rst_level_a",  32'(lvl_a),    0);
        check("rst_cnt_a",    32'(cnt_a),    0);
        check("rst_sticky_b", 32'(sticky_b), 0);
        check("rst_cnt_b",    32'(cnt_b),    0);
        rst = 1'b0;
        tick(4);

        // Single rising edge on ch0: pulses visible after the third edge.
        sig_in[0] = 1'b1;
        tick(2);
        check("c0_rise_early", 32'(rise_a[0]), 0);
        tick(1);
        check("c0_rise",   32'(rise_a[0]), 1);
        check("c0_edge",   32'(edge_a[0]), 1);
        check("c0_level",  32'(lvl_a[0]),  1);
        tick(1);
        check("c0_rise_end", 32'(rise_a[0]), 0);
        check("c0_cnt",      32'(cnt_a[7:0]), 1);

        // Filtered channel: a 3-cycle glitch is rejected, 4 cycles is accepted.
        base_r = n_rise[N_CH+1];
        sig_in[1] = 1'b1;
        tick(3);
        sig_in[1] = 1'b0;
        tick(10);
        check("glitch_rise",  32'(n_rise[N_CH+1] - base_r), 0);
        check("glitch_level", 32'(lvl_b[1]), 0);
        base_r = n_rise[N_CH+1];
        sig_in[1] = 1'b1;
        tick(4);
        sig_in[1] = 1'b0;
        tick(12);
        check("pulse4_rise",  32'(n_rise[N_CH+1] - base_r), 1);
        check("pulse4_level", 32'(lvl_b[1]), 0);

        // Fall-only mode on ch2.
        mode[5:4] = 2'b10;
        clr[2] = 1'b1;
        tick(1);
        clr[2] = 1'b0;
        base_r = n_rise[2];
        base_e = n_edge[2];
        sig_in[2] = 1'b1;
        tick(6);
        check("m10_rise",    32'(n_rise[2] - base_r), 1);
        check("m10_no_edge", 32'(n_edge[2] - base_e), 0);
        check("m10_sticky0", 32'(sticky_a[2]), 0);
        sig_in[2] = 1'b0;
        tick(6);
        check("m10_edge",    32'(n_edge[2] - base_e), 1);
        check("m10_sticky1", 32'(sticky_a[2]), 1);

        // Saturating 2-bit counter on dut_b ch3, then clear coinciding with a pulse.
        clr[3] = 1'b1;
        tick(1);
        clr[3] = 1'b0;
        exp_q = '{32'd1, 32'd2, 32'd3, 32'd3, 32'd3};
        for (int n = 0; n < 6; n++) begin
            sig_in[3] = ~sig_in[3];
            k = 0;
            while (!edge_b[3] && k < 30) begin
                tick(1);
                k++;
            end
            check("sat_edge_seen", 32'(edge_b[3]), 1);
            if (n == 5) clr[3] = 1'b1;
            tick(1);
            clr[3] = 1'b0;
            if (n < 5) begin
                check("sat_seq", 32'(cnt_b[7:6]), exp_q.pop_front());
            end else begin
                check("clr_evt_cnt",    32'(cnt_b[7:6]), 1);
                check("clr_evt_sticky", 32'(sticky_b[3]), 1);
            end
        end

        // All four channels toggle together.
        mode = '1;
        tick(10);
        sig_in = ~sig_in;
        tick(3);
        check("all_edge", 32'(edge_a), 32'hF);
        tick(10);

        // Input held high through reset gives one rise after release.
        sig_in = 4'b0001;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(2);
        check("rsthi_rise_early", 32'(rise_a[0]), 0);
        tick(1);
        check("rsthi_rise", 32'(rise_a[0]), 1);
        tick(1);
        check("rsthi_rise_end", 32'(rise_a[0]), 0);
        tick(6);

        // Reset in the middle of a filter run aborts the pending change.
        sig_in[1] = 1'b1;
        tick(4);
        rst = 1'b1;
        sig_in = '0;
        tick(1);
        check("midrst_level",  32'(lvl_b),    0);
        check("midrst_rise",   32'(rise_b),   0);
        check("midrst_edge",   32'(edge_b),   0);
        check("midrst_sticky", 32'(sticky_b), 0);
        check("midrst_cnt",    32'(cnt_b),    0);
        rst = 1'b0;
        base_r = n_rise[N_CH+1];
        tick(12);
        check("midrst_no_event", 32'(n_rise[N_CH+1] - base_r), 0);
        check("midrst_level2",   32'(lvl_b[1]), 0);

        // Random traffic against the model.
        for (int c = 0; c < N_CH; c++) hold[c] = 0;
        for (int t = 0; t < 800; t++) begin
            for (int c = 0; c < N_CH; c++) begin
                if (hold[c] == 0) begin
                    sig_in[c] = 1'($urandom_range(0, 1));
                    hold[c]   = int'($urandom_range(1, 8));
                end else begin
                    hold[c]--;
                end
            end
            if ($urandom_range(0, 15) == 0) mode = (2*N_CH)'($urandom);
            clr = ($urandom_range(0, 7) == 0) ? N_CH'($urandom) : '0;
            rst = ($urandom_range(0, 149) == 0);
            tick(1);
        end
        rst = 1'b0;
        clr = '0;
        tick(10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
